spi_cntrl: RTL and testbench

//  Byte-oriented SPI controller (main side), SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_pkg.sv | 5 +
 rtl/spi_cntrl.sv | 139 +++++++++++++
 tb/tb_spi_cntrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and byte width for the SPI main controller
package spi_pkg;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, END} spi_state_t;
  localparam int SPI_BITS = 8;
endpackage

// File: rtl/spi_cntrl.sv
// spi_cntrl: byte-oriented SPI mode-0 main controller, MSB first, with optional CS hold between bytes
module spi_cntrl
  import spi_pkg::*;
#(
  parameter int CLK_FREQUENCY  = 100_000_000,
  parameter int SCLK_FREQUENCY = 500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SPI_BITS-1:0] data_to_send,
  input  logic                hold_cs,
  output logic [SPI_BITS-1:0] data_received,
  output logic                busy,
  output logic                done,
  input  logic                SPI_MISO,
  output logic                SPI_SCLK,
  output logic                SPI_MOSI,
  output logic                SPI_CS
);
  localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int CW = (HALF < 2) ? 1 : $clog2(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if (HALF < 2) begin : g_half_check
    $error("spi_cntrl: CLK_FREQUENCY/(2*SCLK_FREQUENCY) must be at least 2");
  end

  spi_state_t          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx, cnt_step;
  logic [2:0]          bit_cnt, bit_nx;
  logic [SPI_BITS-2:0] tx, tx_nx;
  logic [SPI_BITS-1:0] rx, rx_nx, rcv_nx;
  logic                busy_nx, done_nx, sclk_nx, mosi_nx, cs_nx;
  logic                expire, load;

  assign expire   = cnt == LAST;
  assign cnt_step = expire ? '0 : cnt + 1'b1;
  // a new byte can only begin from IDLE or HOLD once the guard/release has finished
  assign load     = start && !busy && (state == IDLE || state == HOLD);

  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_cnt;
    tx_nx    = tx;
    rx_nx    = rx;
    rcv_nx   = data_received;
    busy_nx  = busy;
    done_nx  = 1'b0;
    sclk_nx  = SPI_SCLK;
    mosi_nx  = SPI_MOSI;
    cs_nx    = SPI_CS;
    if (load) begin
      tx_nx    = data_to_send[SPI_BITS-2:0];
      mosi_nx  = data_to_send[SPI_BITS-1];
      cs_nx    = 1'b0;
      bit_nx   = '0;
      cnt_nx   = '0;
      busy_nx  = 1'b1;
      state_nx = LOW;
    end else begin
      case (state)
        IDLE: if (busy) begin
          cnt_nx  = cnt_step;
          busy_nx = !expire;
        end
        LOW: begin
          cnt_nx = cnt_step;
          if (expire) begin
            sclk_nx  = 1'b1;
            rx_nx    = {rx[SPI_BITS-2:0], SPI_MISO};
            state_nx = HIGH;
          end
        end
        HIGH: begin
          cnt_nx = cnt_step;
          if (expire) begin
            sclk_nx = 1'b0;
            if (bit_cnt != 3'(SPI_BITS - 1)) begin
              tx_nx    = {tx[SPI_BITS-3:0], 1'b0};
              mosi_nx  = tx[SPI_BITS-2];
              bit_nx   = bit_cnt + 3'd1;
              state_nx = LOW;
            end else begin
              rcv_nx   = rx;
              done_nx  = 1'b1;
              busy_nx  = !hold_cs;
              state_nx = hold_cs ? HOLD : END;
            end
          end
        end
        HOLD: if (!hold_cs && !start) begin
          busy_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = END;
        end
        END: begin
          cnt_nx = cnt_step;
          if (expire) begin
            cs_nx    = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // state and output registers; reset aborts any transfer and releases CS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      tx            <= '0;
      rx            <= '0;
      data_received <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      SPI_SCLK      <= 1'b0;
      SPI_MOSI      <= 1'b0;
      SPI_CS        <= 1'b1;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      bit_cnt       <= bit_nx;
      tx            <= tx_nx;
      rx            <= rx_nx;
      data_received <= rcv_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      SPI_SCLK      <= sclk_nx;
      SPI_MOSI      <= mosi_nx;
      SPI_CS        <= cs_nx;
    end
  end
endmodule

// File: tb/tb_spi_cntrl.sv
// tb_spi_cntrl: directed scoreboard bench for spi_cntrl with a behavioural mode-0 SPI subunit
module tb_spi_cntrl;
  logic       clk = 1'b0;
  logic       rst_n, start, hold_cs;
  logic [7:0] data_to_send, data_received;
  logic       busy, done, miso, sclk, mosi, cs;
  logic [7:0] send_value = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0, cs_falls = 0, cs_rises = 0, dones = 0, sub_bytes = 0;
  logic [7:0] exp_sub[$];
  logic [7:0] exp_rx[$];

  spi_cntrl #(.CLK_FREQUENCY(100_000_000), .SCLK_FREQUENCY(5_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_to_send(data_to_send),
    .hold_cs(hold_cs), .data_received(data_received), .busy(busy), .done(done),
    .SPI_MISO(miso), .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_CS(cs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // subunit model: presents send_value MSB first, captures MOSI on each SCLK rise
  logic [2:0] bidx = 3'd0;
  logic [7:0] lat = 8'h00, srx = 8'h00;
  assign miso = (bidx == 3'd0) ? send_value[7] : lat[3'd7 - bidx];

  always @(posedge sclk) begin
    if (bidx == 3'd0) lat = send_value;
    srx  = {srx[6:0], mosi};
    bidx = bidx + 3'd1;
    if (bidx == 3'd0) begin
      sub_bytes++;
      if (exp_sub.size() == 0) check("sub_unexpected_byte", {24'h0, srx}, 32'hFFFF_FFFF);
      else check("sub_rx", {24'h0, srx}, {24'h0, exp_sub.pop_front()});
    end
  end

  always @(posedge cs) bidx = 3'd0;

  // pin monitor sampled on the falling clock edge
  int   ncyc = 0, rib = 0, last_rise = 0, hi_at = 0;
  bit   hi_ok = 1'b0;
  logic sclk_p = 1'b0, cs_p = 1'b1;
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      rib   = 0;
      hi_ok = 1'b0;
    end else begin
      if (sclk && !sclk_p) begin
        rises++;
        if (rib > 0) check("sclk_period", ncyc - last_rise, 20);
        last_rise = ncyc;
        rib++;
      end
      if (!cs && cs_p) begin
        cs_falls++;
        if (hi_ok) check("cs_high_gap_ge10", 32'(ncyc - hi_at >= 10), 1);
      end
      if (cs && !cs_p) begin
        cs_rises++;
        hi_at = ncyc;
        hi_ok = 1'b1;
      end
      if (done) begin
        dones++;
        check("rises_per_byte", rib, 8);
        rib = 0;
        if (exp_rx.size() == 0) check("done_unexpected", {24'h0, data_received}, 32'hFFFF_FFFF);
        else check("data_received", {24'h0, data_received}, {24'h0, exp_rx.pop_front()});
      end
    end
    sclk_p = sclk;
    cs_p   = cs;
  end

  task automatic send(input logic [7:0] d, input logic [7:0] sv, input logic h);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check("send_ready", busy, 0);
    send_value   = sv;
    data_to_send = d;
    hold_cs      = h;
    exp_sub.push_back(d);
    exp_rx.push_back(sv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 2000);
    check(tag, done, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || !cs) && n < 2000);
    check(tag, {busy, cs}, 2'b01);
  endtask

  int d0, r0, f0, u0, s0;

  initial begin
    rst_n = 1'b0; start = 1'b0; hold_cs = 1'b0; data_to_send = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", data_received, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte, CS released afterwards
    d0 = dones; r0 = rises; f0 = cs_falls; u0 = cs_rises;
    send(8'hA5, 8'h3C, 1'b0);
    wait_done("t2_done");
    wait_idle("t2_idle");
    check("t2_dones", dones - d0, 1);
    check("t2_rises", rises - r0, 8);
    check("t2_cs_falls", cs_falls - f0, 1);
    check("t2_cs_rises", cs_rises - u0, 1);
    check("t2_rx_held", data_received, 8'h3C);

    // three bytes under one CS assertion
    d0 = dones; f0 = cs_falls; u0 = cs_rises; s0 = sub_bytes;
    send(8'h01, 8'hC1, 1'b1);
    wait_done("t3_done1");
    @(negedge clk);
    check("t3_hold_busy", busy, 0);
    check("t3_hold_cs", cs, 0);
    send(8'h02, 8'h7E, 1'b1);
    wait_done("t3_done2");
    send(8'h03, 8'h99, 1'b0);
    wait_done("t3_done3");
    wait_idle("t3_idle");
    check("t3_dones", dones - d0, 3);
    check("t3_cs_falls", cs_falls - f0, 1);
    check("t3_cs_rises", cs_rises - u0, 1);
    check("t3_sub_bytes", sub_bytes - s0, 3);

    // start while busy is ignored
    d0 = dones; f0 = cs_falls; s0 = sub_bytes;
    send(8'hFF, 8'h96, 1'b0);
    repeat (40) @(negedge clk);
    data_to_send = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done");
    wait_idle("t4_idle");
    check("t4_dones", dones - d0, 1);
    check("t4_sub_bytes", sub_bytes - s0, 1);
    check("t4_cs_falls", cs_falls - f0, 1);

    // asynchronous reset after the fourth SCLK rise aborts the byte
    r0 = rises;
    send(8'hC3, 8'h81, 1'b0);
    for (int i = 0; i < 2000 && rises - r0 < 4; i++) @(negedge clk);
    check("t5_four_rises", rises - r0, 4);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_cs", cs, 1);
    check("t5_rst_sclk", sclk, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_rx", data_received, 0);
    exp_sub.delete();
    exp_rx.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = dones;
    send(8'h5A, 8'hE7, 1'b0);
    wait_done("t5_done");
    wait_idle("t5_idle");
    check("t5_dones", dones - d0, 1);

    // back-to-back bytes with start held high
    d0 = dones; f0 = cs_falls; u0 = cs_rises;
    send_value = 8'h4D; data_to_send = 8'h11; hold_cs = 1'b0;
    exp_sub.push_back(8'h11);
    exp_rx.push_back(8'h4D);
    start = 1'b1;
    wait_done("t6_done1");
    send_value = 8'hB2; data_to_send = 8'h22;
    exp_sub.push_back(8'h22);
    exp_rx.push_back(8'hB2);
    for (int i = 0; i < 2000 && !cs; i++) @(negedge clk);
    check("t6_cs_released", cs, 1);
    for (int i = 0; i < 2000 && cs; i++) @(negedge clk);
    check("t6_cs_reasserted", cs, 0);
    start = 1'b0;
    wait_done("t6_done2");
    wait_idle("t6_idle");
    check("t6_dones", dones - d0, 2);
    check("t6_cs_falls", cs_falls - f0, 2);
    check("t6_cs_rises", cs_rises - u0, 2);
    check("t6_rx_held", data_received, 8'hB2);

    check("sub_queue_empty", exp_sub.size(), 0);
    check("rx_queue_empty", exp_rx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
